// File: rtl/dcache_refill_ctrl_pkg.sv
// Shared definitions for the dcache refill controller.
//  - default address/line widths and watchdog limit
//  - FSM state encoding
`ifndef MEM_ADDRESS_LEN
`define MEM_ADDRESS_LEN 16
`endif

package dcache_refill_ctrl_pkg;

    localparam int ADDR_W_DEF      = `MEM_ADDRESS_LEN;
    localparam int LINE_W_DEF      = 128;
    localparam int TIMEOUT_CYC_DEF = 64;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WB_REQ  = 3'd1,
        ST_WB_WAIT = 3'd2,
        ST_RD_REQ  = 3'd3,
        ST_RD_WAIT = 3'd4,
        ST_RESP    = 3'd5,
        ST_ERR     = 3'd6
    } state_t;

endpackage

// File: rtl/dcache_refill_ctrl_watchdog.sv
// Watchdog counter for the refill controller's WAIT states.
//  clk, reset    : clock / async active-low reset
//  i_clr         : restart the count (asserted on the cycle before a WAIT state)
//  i_en          : count this cycle (asserted while in a WAIT state)
//  o_timeout     : count has reached TIMEOUT_CYC-1 while enabled
module dcache_refill_ctrl_watchdog #(
    parameter int TIMEOUT_CYC = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clr,
    input  logic i_en,
    output logic o_timeout
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] r_cnt;

    // Saturates at LIMIT; the FSM leaves the WAIT state on that cycle anyway.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_cnt <= '0;
        else if (i_clr)
            r_cnt <= '0;
        else if (i_en && (r_cnt != LIMIT))
            r_cnt <= r_cnt + 1'b1;
    end

    assign o_timeout = i_en && (r_cnt == LIMIT);

endmodule

// File: rtl/dcache_refill_ctrl.sv
// Data-cache miss handler towards the memory controller's dcache port.
// On a miss it optionally writes back the dirty victim, then reads the
// missing line and returns it to the cache. One miss in flight at a time;
// a watchdog aborts a miss whose memory response never arrives.
//  miss_req/miss_addr/victim_*      : miss request from the cache (taken in IDLE)
//  busy                             : miss in progress
//  refill_valid/addr/data           : one-cycle line return
//  refill_err                       : one-cycle abort indication
//  from_dcache/is_write/addr_dcache/
//  write_addr/data_from_cache       : request to the memory controller
//  read_ready_for_dcache/
//  written_data_ack/data_to_cache   : responses from the memory controller
module dcache_refill_ctrl
    import dcache_refill_ctrl_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int LINE_W      = LINE_W_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              miss_req,
    input  logic [ADDR_W-1:0] miss_addr,
    input  logic              victim_dirty,
    input  logic [ADDR_W-1:0] victim_addr,
    input  logic [LINE_W-1:0] victim_data,
    output logic              busy,
    output logic              refill_valid,
    output logic [ADDR_W-1:0] refill_addr,
    output logic [LINE_W-1:0] refill_data,
    output logic              refill_err,
    output logic              from_dcache,
    output logic              is_write,
    output logic [ADDR_W-1:0] addr_dcache,
    output logic [ADDR_W-1:0] write_addr,
    output logic [LINE_W-1:0] data_from_cache,
    input  logic              read_ready_for_dcache,
    input  logic              written_data_ack,
    input  logic [LINE_W-1:0] data_to_cache
);

    state_t            r_state, w_next;
    logic [ADDR_W-1:0] r_miss_addr;
    logic [ADDR_W-1:0] r_victim_addr;
    logic [LINE_W-1:0] r_victim_data;
    logic [LINE_W-1:0] r_refill_data;
    logic              w_accept;
    logic              w_in_wait;
    logic              w_timeout;

    assign w_accept  = (r_state == ST_IDLE) && miss_req;
    assign w_in_wait = (r_state == ST_WB_WAIT) || (r_state == ST_RD_WAIT);

    // Every REQ state is followed by its WAIT state, so clearing in REQ
    // starts each WAIT with a count of zero.
    dcache_refill_ctrl_watchdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_watchdog (
        .clk       (clk),
        .reset     (reset),
        .i_clr     (from_dcache),
        .i_en      (w_in_wait),
        .o_timeout (w_timeout)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= ST_IDLE;
            r_miss_addr   <= '0;
            r_victim_addr <= '0;
            r_victim_data <= '0;
            r_refill_data <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_miss_addr   <= miss_addr;
                r_victim_addr <= victim_addr;
                r_victim_data <= victim_data;
            end
            if ((r_state == ST_RD_WAIT) && read_ready_for_dcache)
                r_refill_data <= data_to_cache;
        end
    end

    // Responses only count in the matching WAIT state; a response on the
    // timeout cycle takes priority over the abort.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:    if (miss_req) w_next = victim_dirty ? ST_WB_REQ : ST_RD_REQ;
            ST_WB_REQ:  w_next = ST_WB_WAIT;
            ST_WB_WAIT: if (written_data_ack)      w_next = ST_RD_REQ;
                        else if (w_timeout)        w_next = ST_ERR;
            ST_RD_REQ:  w_next = ST_RD_WAIT;
            ST_RD_WAIT: if (read_ready_for_dcache) w_next = ST_RESP;
                        else if (w_timeout)        w_next = ST_ERR;
            ST_RESP:    w_next = ST_IDLE;
            ST_ERR:     w_next = ST_IDLE;
            default:    w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy         = 1'b0;
        refill_valid = 1'b0;
        refill_err   = 1'b0;
        from_dcache  = 1'b0;
        is_write     = 1'b0;
        if (r_state != ST_IDLE)  busy = 1'b1;
        if (r_state == ST_RESP)  refill_valid = 1'b1;
        if (r_state == ST_ERR)   refill_err = 1'b1;
        if ((r_state == ST_WB_REQ) || (r_state == ST_RD_REQ))  from_dcache = 1'b1;
        if ((r_state == ST_WB_REQ) || (r_state == ST_WB_WAIT)) is_write = 1'b1;
    end

    // Addresses/data come straight from the latches, which only change on
    // acceptance in IDLE, so they are stable for the whole transaction.
    assign addr_dcache     = r_miss_addr;
    assign refill_addr     = r_miss_addr;
    assign write_addr      = r_victim_addr;
    assign data_from_cache = r_victim_data;
    assign refill_data     = r_refill_data;

endmodule

// File: tb/tb_dcache_refill_ctrl.sv
module tb_dcache_refill_ctrl;
    import dcache_refill_ctrl_pkg::*;

    localparam int AW = ADDR_W_DEF;
    localparam int LW = LINE_W_DEF;

    logic          clk = 1'b0;
    logic          reset;
    logic          miss_req;
    logic [AW-1:0] miss_addr;
    logic          victim_dirty;
    logic [AW-1:0] victim_addr;
    logic [LW-1:0] victim_data;
    logic          busy, refill_valid, refill_err, from_dcache, is_write;
    logic [AW-1:0] refill_addr, addr_dcache, write_addr;
    logic [LW-1:0] refill_data, data_from_cache, data_to_cache;
    logic          read_ready_for_dcache, written_data_ack;

    int tests = 0;
    int fails = 0;
    int n_req = 0, n_val = 0, n_err = 0;
    int base_req, base_val, base_err;

    localparam logic [LW-1:0] D_A5 = {16{8'hA5}};
    localparam logic [LW-1:0] D_V  = {8{16'h1234}};
    localparam logic [LW-1:0] D_R2 = {4{32'hCAFE_F00D}};
    localparam logic [LW-1:0] D_5A = {16{8'h5A}};
    localparam logic [LW-1:0] D_T  = {4{32'h0BAD_BEEF}};

    dcache_refill_ctrl dut (
        .clk                   (clk),
        .reset                 (reset),
        .miss_req              (miss_req),
        .miss_addr             (miss_addr),
        .victim_dirty          (victim_dirty),
        .victim_addr           (victim_addr),
        .victim_data           (victim_data),
        .busy                  (busy),
        .refill_valid          (refill_valid),
        .refill_addr           (refill_addr),
        .refill_data           (refill_data),
        .refill_err            (refill_err),
        .from_dcache           (from_dcache),
        .is_write              (is_write),
        .addr_dcache           (addr_dcache),
        .write_addr            (write_addr),
        .data_from_cache       (data_from_cache),
        .read_ready_for_dcache (read_ready_for_dcache),
        .written_data_ack      (written_data_ack),
        .data_to_cache         (data_to_cache)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (from_dcache === 1'b1)  n_req++;
        if (refill_valid === 1'b1) n_val++;
        if (refill_err === 1'b1)   n_err++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b0;
        miss_req = 1'b0; miss_addr = '0; victim_dirty = 1'b0;
        victim_addr = '0; victim_data = '0; data_to_cache = '0;
        read_ready_for_dcache = 1'b0; written_data_ack = 1'b0;

        // reset state
        #3;
        chk("rst_busy", busy, 0);
        chk("rst_req", from_dcache, 0);
        chk("rst_val", refill_valid, 0);
        chk("rst_err", refill_err, 0);
        chk("rst_data", refill_data, 0);
        step(); step();
        reset = 1'b1;
        step();

        // clean miss
        base_req = n_req;
        miss_req = 1; miss_addr = 16'h0040; victim_dirty = 0;
        step();                                   // RD_REQ
        chk("c_busy", busy, 1);
        chk("c_req", from_dcache, 1);
        chk("c_wr", is_write, 0);
        chk("c_addr", addr_dcache, 16'h0040);
        miss_req = 0; miss_addr = 16'h0FFF;
        step();                                   // RD_WAIT 1
        chk("c_req_pulse", from_dcache, 0);
        chk("c_addr_hold", addr_dcache, 16'h0040);
        step(); step();                           // RD_WAIT 3
        read_ready_for_dcache = 1; data_to_cache = D_A5;
        step();                                   // RESP
        chk("c_val", refill_valid, 1);
        chk("c_raddr", refill_addr, 16'h0040);
        chk("c_rdata", refill_data, D_A5);
        read_ready_for_dcache = 0; data_to_cache = '0;
        step();                                   // IDLE
        chk("c_idle", busy, 0);
        chk("c_val_pulse", refill_valid, 0);
        chk("c_data_hold", refill_data, D_A5);
        chk("c_npulse", n_req - base_req, 1);

        // dirty miss
        base_req = n_req;
        miss_req = 1; miss_addr = 16'h0200; victim_dirty = 1;
        victim_addr = 16'h0100; victim_data = D_V;
        step();                                   // WB_REQ
        chk("d_req", from_dcache, 1);
        chk("d_wr", is_write, 1);
        chk("d_waddr", write_addr, 16'h0100);
        chk("d_wdata", data_from_cache, D_V);
        miss_req = 0; victim_dirty = 0; victim_addr = '0; victim_data = '0;
        step();                                   // WB_WAIT
        chk("d_wait_req", from_dcache, 0);
        chk("d_wait_wr", is_write, 1);
        chk("d_wait_wdata", data_from_cache, D_V);
        read_ready_for_dcache = 1;                // wrong response type: ignored
        step();
        chk("d_rdy_ignored", is_write, 1);
        read_ready_for_dcache = 0; written_data_ack = 1;
        step();                                   // RD_REQ
        chk("d_rreq", from_dcache, 1);
        chk("d_rwr", is_write, 0);
        chk("d_raddr", addr_dcache, 16'h0200);
        written_data_ack = 0;
        step();                                   // RD_WAIT
        read_ready_for_dcache = 1; data_to_cache = D_R2;
        step();                                   // RESP
        chk("d_val", refill_valid, 1);
        chk("d_raddr_out", refill_addr, 16'h0200);
        chk("d_rdata", refill_data, D_R2);
        step();                                   // IDLE, ready left high
        chk("d_npulse", n_req - base_req, 2);

        // stale ready level from the previous read
        base_val = n_val;
        miss_req = 1; miss_addr = 16'h0300;
        step();                                   // RD_REQ (ready still high)
        chk("s_req", from_dcache, 1);
        miss_req = 0;
        step();                                   // RD_WAIT
        chk("s_not_done", refill_valid, 0);
        read_ready_for_dcache = 0;
        step();
        chk("s_wait", busy, 1);
        chk("s_nval", n_val - base_val, 0);
        read_ready_for_dcache = 1; data_to_cache = D_5A;
        step();                                   // RESP
        chk("s_val", refill_valid, 1);
        chk("s_rdata", refill_data, D_5A);
        read_ready_for_dcache = 0; data_to_cache = '0;
        step();

        // timeout: no response
        base_val = n_val; base_err = n_err;
        miss_req = 1; miss_addr = 16'h0400;
        step();                                   // RD_REQ
        miss_req = 0;
        step();                                   // WAIT cycle 1
        for (int i = 0; i < 63; i++) step();      // WAIT cycle 64
        chk("t_busy64", busy, 1);
        chk("t_noerr64", refill_err, 0);
        step();                                   // ERR
        chk("t_err", refill_err, 1);
        chk("t_noval", refill_valid, 0);
        step();                                   // IDLE
        chk("t_idle", busy, 0);
        chk("t_nerr", n_err - base_err, 1);
        chk("t_nval", n_val - base_val, 0);

        // response on the last WAIT cycle wins
        base_err = n_err;
        miss_req = 1; miss_addr = 16'h0440;
        step();
        miss_req = 0;
        step();
        for (int i = 0; i < 63; i++) step();      // WAIT cycle 64
        read_ready_for_dcache = 1; data_to_cache = D_T;
        step();
        chk("t64_val", refill_valid, 1);
        chk("t64_noerr", refill_err, 0);
        chk("t64_data", refill_data, D_T);
        read_ready_for_dcache = 0;
        step();
        chk("t64_nerr", n_err - base_err, 0);

        // miss_req held while busy, then back-to-back
        base_req = n_req;
        miss_req = 1; miss_addr = 16'h0500;
        step();                                   // RD_REQ
        miss_addr = 16'h0600;                     // held request changes while busy
        step();                                   // RD_WAIT
        chk("b_addr_hold", addr_dcache, 16'h0500);
        chk("b_req_pulse", from_dcache, 0);
        read_ready_for_dcache = 1; data_to_cache = D_A5;
        step();                                   // RESP
        chk("b_raddr1", refill_addr, 16'h0500);
        read_ready_for_dcache = 0;
        step();                                   // IDLE, accepts 0x0600
        chk("b_idle", busy, 0);
        step();                                   // RD_REQ
        chk("b_req2", from_dcache, 1);
        chk("b_addr2", addr_dcache, 16'h0600);
        miss_req = 0;
        step();
        read_ready_for_dcache = 1; data_to_cache = D_5A;
        step();
        chk("b_raddr2", refill_addr, 16'h0600);
        read_ready_for_dcache = 0;
        step();
        chk("b_npulse", n_req - base_req, 2);

        // reset in WB_WAIT
        base_val = n_val; base_err = n_err;
        miss_req = 1; miss_addr = 16'h0700; victim_dirty = 1;
        victim_addr = 16'h0180; victim_data = D_V;
        step();                                   // WB_REQ
        miss_req = 0; victim_dirty = 0;
        step();                                   // WB_WAIT
        chk("r_pre_wr", is_write, 1);
        #1 reset = 1'b0;
        #1;
        chk("r_busy", busy, 0);
        chk("r_wr", is_write, 0);
        chk("r_waddr", write_addr, 0);
        chk("r_wdata", data_from_cache, 0);
        chk("r_rdata", refill_data, 0);
        #1 reset = 1'b1;
        step(); step();
        chk("r_nval", n_val - base_val, 0);
        chk("r_nerr", n_err - base_err, 0);
        miss_req = 1; miss_addr = 16'h0800;
        step();
        chk("r2_req", from_dcache, 1);
        chk("r2_addr", addr_dcache, 16'h0800);
        miss_req = 0;
        step();
        read_ready_for_dcache = 1; data_to_cache = D_T;
        step();
        chk("r2_val", refill_valid, 1);
        chk("r2_data", refill_data, D_T);
        read_ready_for_dcache = 0;
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
